// File: rtl/bomber_info_status_ctrl.sv
// ----------------------------------------------------------------------------
// bomber_info_status_ctrl
//
// Builds the per-player status words shown by the player-info text overlay.
// At the start of each vertical blank, the raw player state of both players
// is snapshotted. The four X/Y positions are then converted one per cycle
// into a tens bit plus a units nibble, with out-of-range positions clamped to
// POS_MAX. The two finished words are committed to the active bank together,
// so the overlay never sees one player updated and the other not.
//
// Status word layout:
//   [0] X tens, [4:1] X units, [5] Y tens, [9:6] Y units,
//   [11:10] lives, [13:12] bombs
//
// Ports:
//   i_pclk        pixel clock
//   i_rst         synchronous active-high reset
//   i_vblnk       vertical blanking from the timing chain
//   i_p1_*        player 1 raw state (binary position, lives, bombs)
//   i_p2_*        player 2 raw state
//   i_axi_addr    overlay player select (0 = player 1, 1 = player 2)
//   o_axi_data    active status word of the selected player (combinational)
//   o_busy        capture/convert/commit sequence in progress
//   o_frame_done  one-cycle pulse after each commit
//   o_range_err   a position was clamped in the last committed frame
// ----------------------------------------------------------------------------
module bomber_info_status_ctrl #(
  parameter int POS_WIDTH = 5,
  parameter int POS_MAX   = 19   // tens digit is one bit, so at most 19
) (
  input  logic                 i_pclk,
  input  logic                 i_rst,
  input  logic                 i_vblnk,
  input  logic [POS_WIDTH-1:0] i_p1_pos_x,
  input  logic [POS_WIDTH-1:0] i_p1_pos_y,
  input  logic [1:0]           i_p1_lives,
  input  logic [1:0]           i_p1_bombs,
  input  logic [POS_WIDTH-1:0] i_p2_pos_x,
  input  logic [POS_WIDTH-1:0] i_p2_pos_y,
  input  logic [1:0]           i_p2_lives,
  input  logic [1:0]           i_p2_bombs,
  input  logic                 i_axi_addr,
  output logic [13:0]          o_axi_data,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_range_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [POS_WIDTH-1:0] POS_MAX_V = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] TEN       = POS_WIDTH'(10);

  logic [1:0]           state;
  logic                 vblnk_q;
  logic [1:0]           idx;
  logic                 clamp_flag;
  logic                 frame_done_q;
  logic                 range_err_q;

  // Snapshot order matches the conversion index: p1x, p1y, p2x, p2y.
  logic [POS_WIDTH-1:0] snap_pos   [4];
  logic [1:0]           snap_lives [2];
  logic [1:0]           snap_bombs [2];

  logic [13:0]          shadow [2];
  logic [13:0]          active [2];

  logic                 vblank_start;
  logic [POS_WIDTH-1:0] cur_pos;
  logic                 cur_over;
  logic [POS_WIDTH-1:0] cur_clamped;
  logic                 cur_tens;
  logic [3:0]           cur_units;
  logic [4:0]           cur_digits;

  assign vblank_start = i_vblnk & ~vblnk_q;

  // Conversion of the position selected by idx. Clamping first guarantees
  // the value fits a 1-bit tens digit, so one subtraction of 10 suffices.
  always_comb begin
    cur_pos     = snap_pos[idx];
    cur_over    = (cur_pos > POS_MAX_V);
    cur_clamped = cur_over ? POS_MAX_V : cur_pos;
    cur_tens    = (cur_clamped >= TEN);
    cur_units   = 4'(cur_tens ? (cur_clamped - TEN) : cur_clamped);
    cur_digits  = {cur_units, cur_tens};
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      // A vblank already in progress at reset release must not look like
      // a fresh start edge.
      vblnk_q      <= 1'b1;
      idx          <= 2'd0;
      clamp_flag   <= 1'b0;
      frame_done_q <= 1'b0;
      range_err_q  <= 1'b0;
      // NOTE: these arrays are a handful of flops, not a RAM, so they are
      // reset like any other register; that is what makes a mid-sequence
      // reset leave zeros on the overlay instead of a partial frame.
      for (int i = 0; i < 4; i++) snap_pos[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        snap_lives[i] <= 2'd0;
        snap_bombs[i] <= 2'd0;
        shadow[i]     <= 14'd0;
        active[i]     <= 14'd0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in
      // this block samples the pre-edge values of every other one.
      vblnk_q      <= i_vblnk;
      frame_done_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (vblank_start) begin
            snap_pos[0]   <= i_p1_pos_x;
            snap_pos[1]   <= i_p1_pos_y;
            snap_pos[2]   <= i_p2_pos_x;
            snap_pos[3]   <= i_p2_pos_y;
            snap_lives[0] <= i_p1_lives;
            snap_lives[1] <= i_p2_lives;
            snap_bombs[0] <= i_p1_bombs;
            snap_bombs[1] <= i_p2_bombs;
            idx           <= 2'd0;
            clamp_flag    <= 1'b0;
            state         <= S_CONV;
          end
        end

        S_CONV: begin
          if (cur_over) clamp_flag <= 1'b1;

          case (idx)
            2'd0:    shadow[0][4:0] <= cur_digits;
            2'd1:    shadow[0][9:5] <= cur_digits;
            2'd2:    shadow[1][4:0] <= cur_digits;
            default: shadow[1][9:5] <= cur_digits;
          endcase

          if (idx == 2'd0) begin
            shadow[0][13:10] <= {snap_bombs[0], snap_lives[0]};
            shadow[1][13:10] <= {snap_bombs[1], snap_lives[1]};
          end

          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= S_COMMIT;
        end

        S_COMMIT: begin
          active[0]    <= shadow[0];
          active[1]    <= shadow[1];
          range_err_q  <= clamp_flag;
          frame_done_q <= 1'b1;
          state        <= S_IDLE;
        end

        // NOTE: the unused encoding falls back to IDLE so a corrupted state
        // register cannot lock the controller up.
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_axi_data   = active[i_axi_addr];
  assign o_busy       = (state != S_IDLE);
  assign o_frame_done = frame_done_q;
  assign o_range_err  = range_err_q;

endmodule

// File: tb/tb_bomber_info_status_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bomber_info_status_ctrl
//
// Directed and randomized frames against a behavioural model that derives
// each status word with decimal arithmetic (clamp, /10, %10) and tracks the
// active bank and range-error flag at the frame level.
// ----------------------------------------------------------------------------
module tb_bomber_info_status_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic [4:0]  p1_x, p1_y, p2_x, p2_y;
  logic [1:0]  p1_lives, p1_bombs, p2_lives, p2_bombs;
  logic        axi_addr;
  logic [13:0] axi_data;
  logic        busy;
  logic        frame_done;
  logic        range_err;

  int          n_checks = 0;
  int          n_errors = 0;

  // Model state: what the overlay should currently display.
  logic [13:0] exp_active [2];
  logic        exp_err;

  always #5 pclk = ~pclk;

  bomber_info_status_ctrl #(
    .POS_WIDTH (5),
    .POS_MAX   (19)
  ) dut (
    .i_pclk       (pclk),
    .i_rst        (rst),
    .i_vblnk      (vblnk),
    .i_p1_pos_x   (p1_x),
    .i_p1_pos_y   (p1_y),
    .i_p1_lives   (p1_lives),
    .i_p1_bombs   (p1_bombs),
    .i_p2_pos_x   (p2_x),
    .i_p2_pos_y   (p2_y),
    .i_p2_lives   (p2_lives),
    .i_p2_bombs   (p2_bombs),
    .i_axi_addr   (axi_addr),
    .o_axi_data   (axi_data),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_range_err  (range_err)
  );

  function automatic logic [13:0] ref_word(input int x, input int y,
                                           input int lives, input int bombs);
    int xc;
    int yc;
    xc = (x > 19) ? 19 : x;
    yc = (y > 19) ? 19 : y;
    return 14'((xc / 10) + (xc % 10) * 2 + (yc / 10) * 32 + (yc % 10) * 64 +
               lives * 1024 + bombs * 4096);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic scramble_inputs();
    p1_x = 5'($urandom); p1_y = 5'($urandom);
    p2_x = 5'($urandom); p2_y = 5'($urandom);
    p1_lives = 2'($urandom); p1_bombs = 2'($urandom);
    p2_lives = 2'($urandom); p2_bombs = 2'($urandom);
  endtask

  // One complete frame: vblank rising edge with the given player state, then
  // twelve observed cycles. Inputs are scrambled and vblank pulsed during the
  // conversion; neither may influence the frame or start another one.
  task automatic run_frame(input int ax, input int ay, input int al, input int ab,
                           input int bx, input int by, input int bl, input int bb);
    logic [13:0] new_word [2];
    logic        new_err;
    vblnk = 1'b0;
    tick();
    p1_x = 5'(ax); p1_y = 5'(ay); p1_lives = 2'(al); p1_bombs = 2'(ab);
    p2_x = 5'(bx); p2_y = 5'(by); p2_lives = 2'(bl); p2_bombs = 2'(bb);
    vblnk = 1'b1;
    tick();  // capture edge has now passed
    new_word[0] = ref_word(ax, ay, al, ab);
    new_word[1] = ref_word(bx, by, bl, bb);
    new_err     = (ax > 19) || (ay > 19) || (bx > 19) || (by > 19);
    for (int c = 0; c < 12; c++) begin
      axi_addr = 1'(c % 2);
      #1;
      check($sformatf("busy c%0d", c), 32'(busy), 32'(c < 5));
      check($sformatf("frame_done c%0d", c), 32'(frame_done), 32'(c == 5));
      check($sformatf("data c%0d", c), 32'(axi_data),
            32'((c >= 5) ? new_word[c % 2] : exp_active[c % 2]));
      check($sformatf("range_err c%0d", c), 32'(range_err),
            32'((c >= 5) ? new_err : exp_err));
      if (c == 1) begin
        scramble_inputs();
        vblnk = 1'b0;
      end
      if (c == 2) vblnk = 1'b1;
      tick();
    end
    exp_active[0] = new_word[0];
    exp_active[1] = new_word[1];
    exp_err       = new_err;
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b1; axi_addr = 1'b0;
    p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
    p1_lives = '0; p1_bombs = '0; p2_lives = '0; p2_bombs = '0;
    exp_active[0] = 14'd0; exp_active[1] = 14'd0; exp_err = 1'b0;
    tick(); tick();

    // Reset release during vblank: nothing may start.
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      axi_addr = 1'(c % 2);
      #1;
      check("post-reset busy", 32'(busy), 32'd0);
      check("post-reset data", 32'(axi_data), 32'd0);
      check("post-reset frame_done", 32'(frame_done), 32'd0);
      check("post-reset range_err", 32'(range_err), 32'd0);
      tick();
    end

    // Reference frame.
    run_frame(13, 7, 3, 2, 0, 19, 1, 0);
    axi_addr = 1'b0; #1;
    check("ref frame p1 word", 32'(axi_data), 32'h2DC7);
    axi_addr = 1'b1; #1;
    check("ref frame p2 word", 32'(axi_data), 32'h0660);

    // Out-of-range position, then a clean frame clears the error.
    run_frame(4, 10, 2, 1, 25, 9, 0, 3);
    axi_addr = 1'b1; #1;
    check("clamped p2 x field", 32'(axi_data[4:0]), 32'({4'd9, 1'b1}));
    run_frame(9, 11, 1, 1, 18, 2, 2, 2);

    // Boundaries: 0, 9, 10, 19, 20, 31.
    run_frame(0, 9, 0, 0, 10, 19, 3, 3);
    run_frame(20, 31, 1, 2, 19, 0, 2, 1);

    // Reset while converting: no commit, bank cleared, no pulse.
    vblnk = 1'b0;
    tick();
    p1_x = 5'd17; p2_y = 5'd12; p1_lives = 2'd3;
    vblnk = 1'b1;
    tick();   // t0 passed
    tick();   // t1 passed
    tick();   // t2 passed
    rst = 1'b1;
    tick();   // t3 edge sees reset
    rst = 1'b0;
    exp_active[0] = 14'd0; exp_active[1] = 14'd0; exp_err = 1'b0;
    for (int c = 0; c < 6; c++) begin
      axi_addr = 1'(c % 2);
      #1;
      check("mid-reset busy", 32'(busy), 32'd0);
      check("mid-reset frame_done", 32'(frame_done), 32'd0);
      check("mid-reset data", 32'(axi_data), 32'd0);
      check("mid-reset range_err", 32'(range_err), 32'd0);
      tick();
    end

    // Normal operation resumes after the reset.
    run_frame(13, 7, 3, 2, 0, 19, 1, 0);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      run_frame(int'($urandom_range(31)), int'($urandom_range(31)),
                int'($urandom_range(3)),  int'($urandom_range(3)),
                int'($urandom_range(31)), int'($urandom_range(31)),
                int'($urandom_range(3)),  int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
